// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the 8051 external memory bus interface.
// Cycle types are encoded from {we, code}; a write ignores code.
package ext_bus_pkg;

    localparam int DEFAULT_STROBE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        STROBE,
        HOLD
    } bus_state_t;

    typedef logic [1:0] cyc_t;

    localparam cyc_t CYC_RD   = 2'b00;
    localparam cyc_t CYC_CODE = 2'b01;
    localparam cyc_t CYC_WR   = 2'b10;

    function automatic cyc_t cyc_decode(input logic we, input logic code);
        if (we) begin
            return CYC_WR;
        end
        return code ? CYC_CODE : CYC_RD;
    endfunction

endpackage

// File: rtl/ext_bus_if_if.sv
// Core-side request/response bundle of the external bus interface.
// master = the 8051 core, slave = the bus cycle engine.
interface ext_bus_if_if;

    logic        req;
    logic        we;
    logic        code;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  rdata;
    logic        busy;

    modport master (
        output req,
        output we,
        output code,
        output addr,
        output wdata,
        input  ready,
        input  rdata,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  code,
        input  addr,
        input  wdata,
        output ready,
        output rdata,
        output busy
    );

endinterface

// File: rtl/ext_bus_if.sv
// 8051 multiplexed external bus engine: ALE address phase, strobe phase, hold phase.
// Optional macro EXT_BUS_WAIT_EN adds the active-low wait_n input that stretches the strobe.
module ext_bus_if
    import ext_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    ext_bus_if_if.slave bus,
`ifdef EXT_BUS_WAIT_EN
    input  logic       wait_n,
`endif
    output logic [7:0] p0_out,
    output logic       p0_oe,
    input  logic [7:0] p0_in,
    output logic [7:0] p2_out,
    output logic       p2_oe,
    output logic       ale,
    output logic       psen_n,
    output logic       rd_n,
    output logic       wr_n
);

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

    bus_state_t       state_reg;
    cyc_t             cyc_reg;
    logic [7:0]       wdata_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ready_reg;
    logic [7:0]       rdata_reg;
    logic             busy_reg;
    logic             ale_reg;
    logic             psen_n_reg;
    logic             rd_n_reg;
    logic             wr_n_reg;
    logic             p0_oe_reg;
    logic             p2_oe_reg;
    logic [7:0]       p0_out_reg;
    logic [7:0]       p2_out_reg;
    logic             strobe_release;

`ifdef EXT_BUS_WAIT_EN
    assign strobe_release = wait_n;
`else
    assign strobe_release = 1'b1;
`endif

    // Every output register is loaded with the value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cyc_reg    <= CYC_RD;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            ready_reg  <= 1'b0;
            rdata_reg  <= '0;
            busy_reg   <= 1'b0;
            ale_reg    <= 1'b0;
            psen_n_reg <= 1'b1;
            rd_n_reg   <= 1'b1;
            wr_n_reg   <= 1'b1;
            p0_oe_reg  <= 1'b0;
            p2_oe_reg  <= 1'b0;
            p0_out_reg <= '0;
            p2_out_reg <= '0;
        end else begin
            ready_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        state_reg  <= ADDR;
                        cyc_reg    <= cyc_decode(bus.we, bus.code);
                        wdata_reg  <= bus.wdata;
                        busy_reg   <= 1'b1;
                        ale_reg    <= 1'b1;
                        p0_out_reg <= bus.addr[7:0];
                        p2_out_reg <= bus.addr[15:8];
                        p0_oe_reg  <= 1'b1;
                        p2_oe_reg  <= 1'b1;
                    end
                end
                ADDR: begin
                    state_reg <= LATCH;
                    ale_reg   <= 1'b0;
                end
                LATCH: begin
                    state_reg  <= STROBE;
                    cnt_reg    <= STROBE_LOAD;
                    psen_n_reg <= (cyc_reg != CYC_CODE);
                    rd_n_reg   <= (cyc_reg != CYC_RD);
                    wr_n_reg   <= (cyc_reg != CYC_WR);
                    if (cyc_reg == CYC_WR) begin
                        p0_out_reg <= wdata_reg;
                        p0_oe_reg  <= 1'b1;
                    end else begin
                        p0_oe_reg  <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (strobe_release) begin
                        // Read data is sampled on the same edge the strobe rises.
                        state_reg  <= HOLD;
                        psen_n_reg <= 1'b1;
                        rd_n_reg   <= 1'b1;
                        wr_n_reg   <= 1'b1;
                        ready_reg  <= 1'b1;
                        if (cyc_reg != CYC_WR) begin
                            rdata_reg <= p0_in;
                        end
                    end
                end
                HOLD: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    p0_oe_reg <= 1'b0;
                    p2_oe_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_reg;
    assign bus.busy  = busy_reg;
    assign p0_out    = p0_out_reg;
    assign p0_oe     = p0_oe_reg;
    assign p2_out    = p2_out_reg;
    assign p2_oe     = p2_oe_reg;
    assign ale       = ale_reg;
    assign psen_n    = psen_n_reg;
    assign rd_n      = rd_n_reg;
    assign wr_n      = wr_n_reg;

endmodule

// File: tb/tb_ext_bus_if.sv
// Directed bench for ext_bus_if: vector table of single transactions plus
// hand-written back-to-back, mid-strobe reset and (with EXT_BUS_WAIT_EN) wait-state sequences.
module tb_ext_bus_if;

    logic       clk;
    logic       rst;
    logic [7:0] p0_out;
    logic       p0_oe;
    logic [7:0] p0_in;
    logic [7:0] p2_out;
    logic       p2_oe;
    logic       ale;
    logic       psen_n;
    logic       rd_n;
    logic       wr_n;
    logic       wait_n;

    int n_pass;
    int n_total;

    ext_bus_if_if bus_i();

    ext_bus_if dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_i),
`ifdef EXT_BUS_WAIT_EN
        .wait_n (wait_n),
`endif
        .p0_out (p0_out),
        .p0_oe  (p0_oe),
        .p0_in  (p0_in),
        .p2_out (p2_out),
        .p2_oe  (p2_oe),
        .ale    (ale),
        .psen_n (psen_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        code;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  p0_in;
        logic        exp_psen;   // 1 = psen_n expected low during strobe
        logic        exp_rd;
        logic        exp_wr;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},   16'(bus_i.busy), 16'h0);
        chk({tag, " ready"},  16'(bus_i.ready), 16'h0);
        chk({tag, " oe"},     16'({p0_oe, p2_oe}), 16'h0);
        chk({tag, " ale"},    16'(ale), 16'h0);
        chk({tag, " strobes"}, 16'({psen_n, rd_n, wr_n}), 16'h7);
    endtask

    // Starts at a falling edge with the DUT idle; ends at the falling edge of the first IDLE cycle.
    task automatic run_txn(input vec_t v, input int ws, input string tag);
        int last;
        logic in_strobe;
        logic [2:0] exp_str;
        last = 5 + ws;
        bus_i.req   = 1'b1;
        bus_i.we    = v.we;
        bus_i.code  = v.code;
        bus_i.addr  = v.addr;
        bus_i.wdata = v.wdata;
        p0_in       = v.p0_in;
        wait_n      = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            in_strobe = (k >= 3) && (k <= 4 + ws);
            exp_str = in_strobe ? {~v.exp_psen, ~v.exp_rd, ~v.exp_wr} : 3'b111;
            chk($sformatf("%s c%0d ale", tag, k), 16'(ale), 16'(k == 1));
            chk($sformatf("%s c%0d strobes", tag, k), 16'({psen_n, rd_n, wr_n}), 16'(exp_str));
            chk($sformatf("%s c%0d ready", tag, k), 16'(bus_i.ready), 16'(k == last));
            chk($sformatf("%s c%0d p2", tag, k), {7'h0, p2_oe, p2_out}, {7'h0, 1'b1, v.addr[15:8]});
            if (k <= 2) begin
                chk($sformatf("%s c%0d p0", tag, k), {7'h0, p0_oe, p0_out}, {7'h0, 1'b1, v.addr[7:0]});
            end else if (v.we) begin
                chk($sformatf("%s c%0d p0", tag, k), {7'h0, p0_oe, p0_out}, {7'h0, 1'b1, v.wdata});
            end else begin
                chk($sformatf("%s c%0d p0_oe", tag, k), 16'(p0_oe), 16'h0);
            end
            if (k == last) begin
                chk($sformatf("%s rdata", tag), 16'(bus_i.rdata), 16'(v.exp_rdata));
                bus_i.req = 1'b0;
            end
            // Wrong data on the pins until the edge the strobe is meant to rise on.
            p0_in  = (k >= 2 && k < 4 + ws) ? ~v.p0_in : v.p0_in;
            wait_n = (k >= 4 && k <= 3 + ws) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        chk_idle({tag, " idle"});
    endtask

    initial begin
        bit found;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b0;
        wait_n = 1'b1;
        p0_in = 8'h00;
        bus_i.req = 1'b0;
        bus_i.we = 1'b0;
        bus_i.code = 1'b0;
        bus_i.addr = 16'h0000;
        bus_i.wdata = 8'h00;

        vecs[0] = '{we:1'b0, code:1'b1, addr:16'h1234, wdata:8'h00, p0_in:8'hA5,
                    exp_psen:1'b1, exp_rd:1'b0, exp_wr:1'b0, exp_rdata:8'hA5};
        vecs[1] = '{we:1'b0, code:1'b0, addr:16'h00FF, wdata:8'h00, p0_in:8'h3C,
                    exp_psen:1'b0, exp_rd:1'b1, exp_wr:1'b0, exp_rdata:8'h3C};
        vecs[2] = '{we:1'b1, code:1'b0, addr:16'h8001, wdata:8'h5A, p0_in:8'hEE,
                    exp_psen:1'b0, exp_rd:1'b0, exp_wr:1'b1, exp_rdata:8'h3C};
        vecs[3] = '{we:1'b1, code:1'b1, addr:16'hFFFF, wdata:8'hC3, p0_in:8'h11,
                    exp_psen:1'b0, exp_rd:1'b0, exp_wr:1'b1, exp_rdata:8'h3C};
        vecs[4] = '{we:1'b0, code:1'b0, addr:16'h0000, wdata:8'hFF, p0_in:8'h81,
                    exp_psen:1'b0, exp_rd:1'b1, exp_wr:1'b0, exp_rdata:8'h81};

        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset rdata", 16'(bus_i.rdata), 16'h0);
        chk("reset p0/p2 out", {p2_out, p0_out}, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post-reset");

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i], 0, $sformatf("vec%0d", i));
            $display("vec%0d addr=%h we=%0d code=%0d rdata=%h", i, vecs[i].addr,
                     vecs[i].we, vecs[i].code, bus_i.rdata);
        end

        // Back-to-back: req stays high, next ALE follows exactly one IDLE cycle after ready.
        bus_i.req = 1'b1;
        bus_i.we = 1'b0;
        bus_i.code = 1'b1;
        bus_i.addr = 16'h1111;
        p0_in = 8'h11;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("b2b c%0d ale", k), 16'(ale), 16'(k == 1));
            chk($sformatf("b2b c%0d ready", k), 16'(bus_i.ready), 16'(k == 5));
        end
        bus_i.addr = 16'h2222;
        @(negedge clk);
        chk("b2b gap ale", 16'(ale), 16'h0);
        chk("b2b gap busy", 16'(bus_i.busy), 16'h0);
        @(negedge clk);
        chk("b2b second ale", 16'(ale), 16'h1);
        chk("b2b second addr", {p2_out, p0_out}, 16'h2222);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus_i.ready) begin
                found = 1'b1;
            end
        end
        bus_i.req = 1'b0;
        chk("b2b second ready seen", 16'(found), 16'h1);
        chk("b2b second rdata", 16'(bus_i.rdata), 16'h11);
        $display("b2b addr=1111,2222 rdata=%h", bus_i.rdata);
        @(negedge clk);

        // Reset in the first strobe cycle of a read aborts with no ready.
        bus_i.req = 1'b1;
        bus_i.we = 1'b0;
        bus_i.code = 1'b0;
        bus_i.addr = 16'h4242;
        p0_in = 8'h77;
        repeat (3) @(negedge clk);
        chk("abort rd_n low", 16'(rd_n), 16'h0);
        rst = 1'b0;
        bus_i.req = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        chk("abort rdata", 16'(bus_i.rdata), 16'h0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort no ready %0d", k), 16'({bus_i.ready, bus_i.busy}), 16'h0);
        end
        $display("abort addr=4242 rdata=%h", bus_i.rdata);

`ifdef EXT_BUS_WAIT_EN
        begin
            vec_t wv;
            wv = '{we:1'b0, code:1'b0, addr:16'h0F0F, wdata:8'h00, p0_in:8'h96,
                   exp_psen:1'b0, exp_rd:1'b1, exp_wr:1'b0, exp_rdata:8'h96};
            run_txn(wv, 3, "wait");
            $display("wait addr=0F0F rdata=%h", bus_i.rdata);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
